// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: frames A5/LEN_LO/LEN_HI/data into 32-bit little-endian word writes,
// holding the CPU in reset until the image is in. Define LOADER_CHECKSUM_EN for a trailing sum byte.
module uart_prog_loader #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  btn2,
    input  logic                  uart_rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      CAPACITY     = 17'(1 << ADDR_WIDTH);
    localparam logic [7:0]       SOF          = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE, L_LEN_LO, L_LEN_HI, L_DATA,
`ifdef LOADER_CHECKSUM_EN
        L_CHK,
`endif
        L_DONE, L_ERR
    } ld_state_t;

    rx_state_t        rx_state;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             byte_valid, frame_err;

    ld_state_t        ld_state;
    logic [7:0]       len_lo;
    logic [15:0]      words_left;
    logic [1:0]       byte_idx;
    logic             ld_open;

    // Receiver: the sync flops reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge btn2) begin
        if (!btn2) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees the pre-edge values of the others.
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_state   <= RX_IDLE;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A frame is open (errors matter) everywhere except the three resting states.
    assign ld_open = !(ld_state inside {L_IDLE, L_DONE, L_ERR});

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_sum;

    always_ff @(posedge clk or negedge btn2) begin
        if (!btn2) begin
            chk_sum <= '0;
        end else if (byte_valid) begin
            if (!ld_open)
                chk_sum <= '0;
            else if (ld_state != L_CHK)
                chk_sum <= chk_sum + rx_shift;
        end
    end
`endif

    always_ff @(posedge clk or negedge btn2) begin
        if (!btn2) begin
            ld_state   <= L_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst_n  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            words_left <= '0;
            byte_idx   <= '0;
        end else begin
            mem_we <= 1'b0;
            // The address stays on the last word written once the image is complete.
            if (mem_we && words_left != '0) mem_addr <= mem_addr + 1'b1;

            if (byte_valid && rx_shift == SOF && !ld_open) begin
                ld_state  <= L_LEN_LO;
                cpu_rst_n <= 1'b0;
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                mem_addr  <= '0;
            end else if (frame_err && ld_open) begin
                ld_state  <= L_ERR;
                busy      <= 1'b0;
                err       <= 1'b1;
                cpu_rst_n <= 1'b0;
            end else if (byte_valid) begin
                case (ld_state)
                    L_LEN_LO: begin
                        len_lo   <= rx_shift;
                        ld_state <= L_LEN_HI;
                    end
                    L_LEN_HI: begin
                        words_left <= {rx_shift, len_lo};
                        byte_idx   <= '0;
                        if ({rx_shift, len_lo} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            ld_state  <= L_CHK;
`else
                            ld_state  <= L_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
`endif
                        end else if ({1'b0, rx_shift, len_lo} > CAPACITY) begin
                            ld_state <= L_ERR;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            ld_state <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_shift;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            mem_we     <= 1'b1;
                            words_left <= words_left - 1'b1;
                            if (words_left == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                ld_state  <= L_CHK;
`else
                                ld_state  <= L_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                cpu_rst_n <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    L_CHK: begin
                        busy <= 1'b0;
                        if (rx_shift == chk_sum) begin
                            ld_state  <= L_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            ld_state <= L_ERR;
                            err      <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: serialises frames, predicts writes and final status
// from the frame rules, and a monitor compares every mem_we strobe against the expected queue.
`timescale 1ns/1ps
module tb_uart_prog_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;
    localparam int CPB = 4;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          btn2 = 1'b0;
    logic          uart_rx = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst_n, busy, done, err;

    int          n_cmp = 0;
    int          n_fail = 0;
    wr_t         exp_q[$];
    logic [31:0] img[$];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_FREQ  (1000000),
        .BAUD      (250000),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .btn2     (btn2),
        .uart_rx  (uart_rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        wr_t e;
        if (btn2 && mem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write (t=%0t)",
                         mem_addr, mem_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Sends A5, LEN, data words from img (if len fits), optional checksum; bad_stop_at is a byte
    // index whose stop bit is forced low (transmission stops there), -1 for none.
    task automatic run_frame(input string tag, input int len, input int bad_stop_at, input bit bad_chk);
        logic [7:0] frame[$];
        logic [7:0] sum;
        logic [7:0] b;
        bit         oversize;
        bit         exp_err;
        wr_t        w;
        oversize = (len > CAP);
        frame.push_back(8'hA5);
        frame.push_back(len[7:0]);
        frame.push_back(len[15:8]);
        sum = len[7:0] + len[15:8];
        if (!oversize) begin
            for (int i = 0; i < img.size(); i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = img[i][8*k +: 8];
                    frame.push_back(b);
                    sum = sum + b;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            frame.push_back(bad_chk ? sum + 8'd1 : sum);
`endif
            // Word i completes with frame byte 6+4i; it lands only if that byte precedes a bad stop.
            for (int i = 0; i < img.size(); i++) begin
                if (bad_stop_at < 0 || 6 + 4 * i < bad_stop_at) begin
                    w.addr = i;
                    w.data = img[i];
                    exp_q.push_back(w);
                end
            end
        end
        exp_err = oversize || (bad_stop_at >= 0);
`ifdef LOADER_CHECKSUM_EN
        exp_err = exp_err || (bad_chk && !oversize);
`endif
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], i == bad_stop_at);
            if (i == 2 && !oversize && len > 0 && (bad_stop_at < 0 || bad_stop_at > 2)) begin
                check({tag, "_mid_busy"}, 32'(busy), 1);
                check({tag, "_mid_cpu_rst_n"}, 32'(cpu_rst_n), 0);
            end
            if (i == bad_stop_at) break;
        end
        repeat (4) @(negedge clk);
        check_status(tag, !exp_err, exp_err);
    endtask

    initial begin
        int n;
        int mode;
        wr_t w;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        btn2 = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_done", 32'(done), 0);
        check("idle_cpu_rst_n", 32'(cpu_rst_n), 1);

        // Two-word load
        img.delete();
        img.push_back(32'h00500013);
        img.push_back(32'h05100393);
        run_frame("load2", 2, -1, 1'b0);

        // Noise bytes then an empty image
        send_byte(8'h3C, 1'b0);
        send_byte(8'h00, 1'b0);
        check("noise_busy", 32'(busy), 0);
        img.delete();
        run_frame("zero", 0, -1, 1'b0);

        // Oversize length, then recovery
        img.delete();
        run_frame("oversize", 5, -1, 1'b0);
        img.push_back(32'hDEADBEEF);
        run_frame("recover", 1, -1, 1'b0);

        // Full capacity: last write lands on the top address
        img.delete();
        for (int i = 0; i < CAP; i++) img.push_back($urandom);
        run_frame("full", CAP, -1, 1'b0);

        // Framing error in the middle of the second word
        img.delete();
        img.push_back($urandom);
        img.push_back($urandom);
        run_frame("framing", 2, 9, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        img.delete();
        img.push_back(32'h04030201);
        run_frame("chk_ok", 1, -1, 1'b0);
        run_frame("chk_bad", 1, -1, 1'b1);
`endif

        // Randomised frames
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, CAP);
            mode = $urandom_range(0, 5);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            case (mode)
                0: begin
                    img.delete();
                    run_frame("rnd_oversize", CAP + 1 + $urandom_range(0, 300), -1, 1'b0);
                end
                1: run_frame("rnd_framing", n, $urandom_range(1, 3 + 4 * n - 1), 1'b0);
                2: run_frame("rnd_chk", n, -1, 1'b1);
                default: run_frame("rnd_load", n, -1, 1'b0);
            endcase
        end

        // Reset pulse mid-load: one word written, then immediate return to reset values
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        w.addr = 0;
        w.data = img[0];
        exp_q.push_back(w);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(img[k / 4][8 * (k % 4) +: 8], 1'b0);
        check("midrst_busy_before", 32'(busy), 1);
        #3 btn2 = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 0);
        check("midrst_mem_addr", 32'(mem_addr), 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_cpu_rst_n", 32'(cpu_rst_n), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        btn2 = 1'b1;

        // Loader still works after the reset
        img.delete();
        img.push_back($urandom);
        run_frame("post_rst", 1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
